// File: rtl/cla_check_pkg.sv
// ---------------------------------------------------------------------------
// cla_check_pkg
//   Shared types and constants for the carry-lookahead adder result checker.
//   - state_e      : checker run-control states
//   - DEFAULT_*    : default operand / counter widths
//   - golden_sum() : reference sum (zero-extended, carry-out in the MSB),
//                    usable by benches that model the default-width adder
// ---------------------------------------------------------------------------
package cla_check_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Reference sum of two default-width operands; the carry lands in bit WIDTH.
  function automatic logic [DEFAULT_WIDTH:0] golden_sum(
    input logic [DEFAULT_WIDTH-1:0] a,
    input logic [DEFAULT_WIDTH-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage : cla_check_pkg

// File: rtl/cla_check_pipe.sv
// ---------------------------------------------------------------------------
// cla_check_pipe
//   Two-stage, never-stalling compare pipeline.
//   S1 captures the operands and the netlist result of an accepted vector.
//   The golden sum is formed from the S1 registers, and S2 captures the
//   golden sum, the netlist result and their mismatch flag.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset (clears valid bits only)
//   in_valid_i     vector accepted this cycle
//   add1_i/add2_i  operands
//   result_i       netlist sum under test (WIDTH+1 bits)
//   s1_valid_o     S1 holds a vector
//   s2_valid_o     S2 holds a vector (it leaves the pipe this cycle)
//   s2_mismatch_o  golden sum differs from the netlist result
//   s2_exp_o       golden sum held in S2
//   s2_got_o       netlist result held in S2
// ---------------------------------------------------------------------------
module cla_check_pipe
  import cla_check_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [WIDTH:0]   result_i,
  output logic             s1_valid_o,
  output logic             s2_valid_o,
  output logic             s2_mismatch_o,
  output logic [WIDTH:0]   s2_exp_o,
  output logic [WIDTH:0]   s2_got_o
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [WIDTH:0]   s1_got_q;

  logic             s2_valid_q;
  logic             s2_mismatch_q;
  logic [WIDTH:0]   s2_exp_q;
  logic [WIDTH:0]   s2_got_q;

  logic [WIDTH:0]   golden_d;
  logic             mismatch_d;

  // Golden adder and compare sit between S1 and S2.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    golden_d   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    mismatch_d = 1'b1;
    // Written as "equal clears the flag" so an X on the netlist result
    // falls through as a mismatch in four-state simulation.
    if (golden_d == s1_got_q) begin
      mismatch_d = 1'b0;
    end
  end

  // Valid bits: the only pipeline state that needs a reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid_i;
      s2_valid_q <= s1_valid_q;
    end
  end

  // NOTE: datapath registers are deliberately not reset; nothing downstream
  // looks at them unless the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (in_valid_i) begin
      s1_a_q   <= add1_i;
      s1_b_q   <= add2_i;
      s1_got_q <= result_i;
    end
    if (s1_valid_q) begin
      s2_mismatch_q <= mismatch_d;
      s2_exp_q      <= golden_d;
      s2_got_q      <= s1_got_q;
    end
  end

  assign s1_valid_o    = s1_valid_q;
  assign s2_valid_o    = s2_valid_q;
  assign s2_mismatch_o = s2_mismatch_q;
  assign s2_exp_o      = s2_exp_q;
  assign s2_got_o      = s2_got_q;

endmodule : cla_check_pipe

// File: rtl/cla_result_checker.sv
// ---------------------------------------------------------------------------
// cla_result_checker
//   Response checker for the locked 16-bit carry-lookahead adder netlists.
//   Vectors (operands + netlist sum) arrive over valid/ready, are compared
//   against a golden sum in cla_check_pipe, and the results are accumulated
//   into saturating vector/error counters plus a first-failure record.
//   A run starts on start_i and finishes after the vector flagged last_i
//   has drained through the pipe; done_o/pass_o then hold the verdict.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   start_i          pulse: clear results and begin a run (IDLE/DONE only)
//   vec_valid_i      vector present on add1_i/add2_i/result_i/last_i
//   vec_ready_o      vector accepted this cycle when valid (RUN only)
//   add1_i, add2_i   operands
//   result_i         netlist sum under test (WIDTH+1 bits)
//   last_i           final vector of the run
//   err_pulse_o      one-cycle pulse per mismatching vector
//   vec_cnt_o        vectors compared (saturating)
//   err_cnt_o        mismatches (saturating)
//   first_err_idx_o  0-based index of the first mismatch
//   first_err_exp_o  golden sum of the first mismatch
//   first_err_got_o  netlist result of the first mismatch
//   done_o           run complete, held until start_i or reset
//   pass_o           meaningful with done_o; 1 iff no mismatches
// ---------------------------------------------------------------------------
module cla_result_checker
  import cla_check_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [WIDTH:0]   result_i,
  input  logic             last_i,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] first_err_idx_o,
  output logic [WIDTH:0]   first_err_exp_o,
  output logic [WIDTH:0]   first_err_got_o,
  output logic             done_o,
  output logic             pass_o
);

  state_e           state_q;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_idx_q;
  logic [WIDTH:0]   first_exp_q;
  logic [WIDTH:0]   first_got_q;
  logic             err_pulse_q;
  logic             done_q;
  logic             pass_q;

  logic             accept;
  logic             err_hit;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_mismatch;
  logic [WIDTH:0]   s2_exp;
  logic [WIDTH:0]   s2_got;

  assign vec_ready_o = (state_q == RUN);
  assign accept      = vec_valid_i & vec_ready_o;

  cla_check_pipe #(
    .WIDTH (WIDTH)
  ) u_pipe (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (accept),
    .add1_i        (add1_i),
    .add2_i        (add2_i),
    .result_i      (result_i),
    .s1_valid_o    (s1_valid),
    .s2_valid_o    (s2_valid),
    .s2_mismatch_o (s2_mismatch),
    .s2_exp_o      (s2_exp),
    .s2_got_o      (s2_got)
  );

  assign err_hit = s2_valid & s2_mismatch;

  // Saturating counter next-state: a full counter holds instead of wrapping.
  always_comb begin
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    if (s2_valid && (vec_cnt_q != {CNT_W{1'b1}})) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
    end
    if (err_hit && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Run control, counters and first-failure record.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
      err_pulse_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      err_pulse_q <= err_hit;
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;

      // Only the first mismatch of a run is recorded; the pre-increment
      // vector count is that vector's 0-based index.
      if (err_hit && (err_cnt_q == '0)) begin
        first_idx_q <= vec_cnt_q;
        first_exp_q <= s2_exp;
        first_got_q <= s2_got;
      end

      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q     <= RUN;
            vec_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        RUN: begin
          if (accept && last_i) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Once S1 is empty, the vector in S2 (if any) is counted on this
          // same edge, so the verdict uses the post-update error count.
          if (!s1_valid) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err_pulse_o     = err_pulse_q;
  assign vec_cnt_o       = vec_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_idx_o = first_idx_q;
  assign first_err_exp_o = first_exp_q;
  assign first_err_got_o = first_got_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;

endmodule : cla_result_checker
